// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray counter and its synchronizer consumers.
// The helpers work on 32-bit zero-extended values. Zero bits above the live
// width do not change either conversion, so one function body serves every
// counter width from 1 to 32.
package gray_pkg;

  // Widest counter the helpers support.
  localparam int unsigned GRAY_MAX_SIZE = 32;

  // Mask of the live bits for a given width, i.e. 2^size-1.
  function automatic logic [31:0] gray_mask(input int unsigned size);
    logic [31:0] m;
    if (size >= GRAY_MAX_SIZE) begin
      m = 32'hFFFF_FFFF;
    end else begin
      m = (32'd1 << size) - 32'd1;
    end
    return m;
  endfunction

  // Binary to reflected-binary Gray code.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected-binary Gray code to binary, computed as a running XOR from the MSB down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder. It is kept as its own block so that
// synchronizer consumers can decode a crossed pointer with the same logic.
module gray2bin #(
  parameter int unsigned SIZE = 5
) (
  input  logic [SIZE-1:0] g,
  output logic [SIZE-1:0] b
);

  // Decode through the shared helper, zero-extending the input and truncating the result.
  always_comb begin
    b = SIZE'(gray_pkg::gray2bin(32'(g)));
  end

endmodule

// File: rtl/gray_inc_counter.sv
// Free-running Gray-code counter. It advances by a fixed binary step INC every
// clock and wraps modulo 2^SIZE. The only state is the Gray register, which
// drives the output directly so that clock-domain-crossing logic sees clean flops.
module gray_inc_counter
  import gray_pkg::*;
#(
  parameter int unsigned SIZE = 5,
  parameter int unsigned INC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [SIZE-1:0] gray
);

  localparam logic [31:0]     MASK   = gray_mask(SIZE);
  localparam logic [31:0]     INC_32 = 32'(INC);
  localparam logic [SIZE-1:0] INC_W  = SIZE'(INC_32 & MASK);

  // Reject widths the helpers cannot represent and steps that do not fit the counter.
  if ((SIZE < 1) || (SIZE > GRAY_MAX_SIZE)) begin : g_bad_size
    $error("gray_inc_counter: SIZE must be within 1..32");
  end
  if ((INC_32 & ~MASK) != 32'd0) begin : g_bad_inc
    $error("gray_inc_counter: INC must be below 2^SIZE");
  end

  logic [SIZE-1:0] gray_q;
  logic [SIZE-1:0] gray_d;
  logic [SIZE-1:0] bin_s;
  logic [SIZE-1:0] sum_s;

  gray2bin #(
    .SIZE (SIZE)
  ) u_dec (
    .g (gray_q),
    .b (bin_s)
  );

  // Next state: step the decoded binary value, drop the carry, and re-encode to Gray.
  always_comb begin
    sum_s  = bin_s + INC_W;
    gray_d = SIZE'(bin2gray(32'(sum_s)));
  end

  // Gray state register; reset clears it at once, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign gray = gray_q;

endmodule

// File: tb/tb_gray_inc_counter.sv
// Scoreboard bench for gray_inc_counter. The stimulus process drives reset and
// pushes the expected value for each DUT into a queue after every edge. The
// monitor drains the queue at each falling edge, or on demand between edges.
module tb_gray_inc_counter;

  typedef struct {
    int         sel;
    logic [4:0] exp;
    logic       onebit;
    string      tag;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [4:0] gray_def;
  logic [3:0] gray_s4;
  logic [4:0] gray_z;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  event sample_ev;

  gray_inc_counter #(.SIZE(5), .INC(1)) dut_def (.clk(clk), .rst_n(rst_n), .gray(gray_def));
  gray_inc_counter #(.SIZE(4), .INC(3)) dut_s4  (.clk(clk), .rst_n(rst_n), .gray(gray_s4));
  gray_inc_counter #(.SIZE(5), .INC(0)) dut_z   (.clk(clk), .rst_n(rst_n), .gray(gray_z));

  // 20 ns clock, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Bench-side Gray encodings of a binary count.
  function automatic logic [4:0] g5(input int k);
    logic [4:0] b;
    b = 5'(k % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g4(input int k);
    logic [3:0] b;
    b = 4'(k % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic push(input int sel, input logic [4:0] e, input logic ob, input string tag);
    exp_t x;
    x.sel = sel;
    x.exp = e;
    x.onebit = ob;
    x.tag = tag;
    sb_q.push_back(x);
  endtask

  // Monitor: pop and compare every pending expectation.
  initial begin
    exp_t       e;
    logic [4:0] act;
    logic [4:0] prev0;
    prev0 = 5'd0;
    checks = 0;
    errors = 0;
    forever begin
      @(negedge clk or sample_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          0:       act = gray_def;
          1:       act = {1'b0, gray_s4};
          default: act = gray_z;
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s dut%0d: got %b expected %b at %0t", e.tag, e.sel, act, e.exp, $time);
        end
        if (e.onebit) begin
          checks++;
          if ($countones(act ^ prev0) != 1) begin
            errors++;
            $display("FAIL onebit dut0: %b -> %b changes %0d bits, expected 1 at %0t",
                     prev0, act, $countones(act ^ prev0), $time);
          end
        end
        if (e.sel == 0) prev0 = act;
      end
    end
  end

  // Stimulus with hand-computed expectations.
  initial begin
    logic [4:0] seq8 [8];
    logic [3:0] s4tbl [4];
    logic [4:0] e0;
    logic [3:0] e1;
    seq8[0] = 5'b00001; seq8[1] = 5'b00011; seq8[2] = 5'b00010; seq8[3] = 5'b00110;
    seq8[4] = 5'b00111; seq8[5] = 5'b00101; seq8[6] = 5'b00100; seq8[7] = 5'b01100;
    // Gray of binary 3, 6, 9, 12.
    s4tbl[0] = 4'b0010; s4tbl[1] = 4'b0101; s4tbl[2] = 4'b1101; s4tbl[3] = 4'b1010;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    push(0, 5'd0, 1'b0, "reset");
    push(1, 5'd0, 1'b0, "reset");
    push(2, 5'd0, 1'b0, "reset");
    #14;
    rst_n = 1'b1;  // release at 25 ns

    // 40 edges: first eight from the table, wrap at 31..33, INC=3 and INC=0 side by side.
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k <= 8) e0 = seq8[k-1];
      else        e0 = g5(k);
      push(0, e0, (k <= 33) ? 1'b1 : 1'b0, (k >= 31 && k <= 33) ? "wrap" : "seq");
      if (k <= 4) e1 = s4tbl[k-1];
      else        e1 = g4(3 * k);
      push(1, {1'b0, e1}, 1'b0, "inc3");
      push(2, 5'd0, 1'b0, "inc0");
    end

    // Restart all counters with a reset pulse placed between edges.
    #11;
    rst_n = 1'b0;
    #2;
    push(0, 5'd0, 1'b0, "rst2");
    push(1, 5'd0, 1'b0, "rst2");
    push(2, 5'd0, 1'b0, "rst2");
    ->sample_ev;
    #2;
    rst_n = 1'b1;

    // Count up to 00110, then pulse reset low before the next edge.
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      push(0, seq8[k-1], 1'b0, "recount");
    end
    #11;
    rst_n = 1'b0;
    #2;
    push(0, 5'd0, 1'b0, "async_rst");
    ->sample_ev;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk);
      #1;
      push(0, seq8[k-1], 1'b0, "resume");
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
